nios2_oci_debug_ram_ctrl: RTL and testbench

Debug-RAM controller for the Nios II on-chip instrumentation (OCI). It sits directly downstream of the JTAG debug module's system-clock stage and consumes its `jdo` bus and `take_action_ocimem_*` / `take_no_action_ocimem_a` pulses. It executes JTAG address-load, read and write commands against a single-port debug RAM, and arbitrates that RAM with the CPU's Avalon-MM debug slave port. Read results return to the JTAG scan path on `MonDReg`.

---
 rtl/nios2_oci_debug_ram_ctrl_if.sv | 40 ++++
 rtl/nios2_oci_debug_ram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_nios2_oci_debug_ram_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_oci_debug_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nios2_oci_debug_ram_ctrl_if
// Brief    : JTAG command, CPU Avalon-MM and monitor signals of the OCI
//            debug-RAM controller.
// Revision : 1.0
// ============================================================================
interface nios2_oci_debug_ram_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              debugaccess;
    logic [31:0]       readdata;
    logic              waitrequest;
    logic [31:0]       MonDReg;
    logic [ADDR_W-1:0] MonAReg;
    logic              jtag_rd_done;
    logic              cmd_overrun;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output address, read, write, writedata, byteenable, debugaccess,
        input  readdata, waitrequest, MonDReg, MonAReg, jtag_rd_done, cmd_overrun
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  address, read, write, writedata, byteenable, debugaccess,
        output readdata, waitrequest, MonDReg, MonAReg, jtag_rd_done, cmd_overrun
    );
endinterface
`default_nettype wire

// File: rtl/nios2_oci_debug_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nios2_oci_debug_ram_ctrl
// Brief    : Nios II OCI debug-RAM controller; JTAG commands win the single
//            RAM port over the CPU debug slave. Optional macro:
//            NIOS2_OCIMEM_WRITE_PROTECT_EN (CPU writes need debugaccess).
// Revision : 1.0
// ============================================================================
module nios2_oci_debug_ram_ctrl #(
    parameter int ADDR_W = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    nios2_oci_debug_ram_ctrl_if.slave  bus
);
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_J_RD   = 2'd1;
    localparam logic [1:0] c_ST_C_RD   = 2'd2;
    localparam logic [1:0] c_CMD_LOAD  = 2'd0;
    localparam logic [1:0] c_CMD_READ  = 2'd1;
    localparam logic [1:0] c_CMD_WRITE = 2'd2;

    logic [1:0]        r_state, w_next_state;
    logic              r_cmd_valid, r_cmd_rdflag;
    logic [1:0]        r_cmd_type;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [31:0]       r_cmd_data;
    logic [ADDR_W-1:0] r_mon_areg;
    logic [31:0]       r_mon_dreg, r_readdata, r_ram_q;
    logic              r_rd_done, r_overrun, r_cpu_rd_ack;
    logic [31:0]       r_mem [2**ADDR_W];

    logic              w_cmd_simple, w_consume, w_any_pulse, w_multi_pulse, w_capture;
    logic              w_ram_rd, w_jtag_we, w_cpu_we, w_waitrequest, w_cpu_wr_allow;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_unused_bits;

`ifdef NIOS2_OCIMEM_WRITE_PROTECT_EN
    assign w_cpu_wr_allow = bus.debugaccess;
    assign w_unused_bits  = ^{bus.jdo[37:36], bus.jdo[2:0]};
`else
    assign w_cpu_wr_allow = 1'b1;
    assign w_unused_bits  = ^{bus.jdo[37:36], bus.jdo[2:0], bus.debugaccess};
`endif

    // LOAD without read and WRITE finish in their single IDLE cycle
    assign w_cmd_simple  = (r_cmd_type == c_CMD_WRITE) || ((r_cmd_type == c_CMD_LOAD) && !r_cmd_rdflag);
    assign w_consume     = (r_state == c_ST_J_RD) || ((r_state == c_ST_IDLE) && r_cmd_valid && w_cmd_simple);
    assign w_any_pulse   = bus.take_action_ocimem_b | bus.take_action_ocimem_a | bus.take_no_action_ocimem_a;
    assign w_multi_pulse = (bus.take_action_ocimem_b & bus.take_action_ocimem_a)
                         | (bus.take_action_ocimem_b & bus.take_no_action_ocimem_a)
                         | (bus.take_action_ocimem_a & bus.take_no_action_ocimem_a);
    assign w_capture     = w_any_pulse && (!r_cmd_valid || w_consume);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_valid  <= 1'b0;
            r_cmd_type   <= c_CMD_LOAD;
            r_cmd_addr   <= '0;
            r_cmd_rdflag <= 1'b0;
            r_cmd_data   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cmd_valid  <= 1'b1;
                r_cmd_addr   <= bus.jdo[26 +: ADDR_W];
                r_cmd_rdflag <= bus.jdo[35];
                r_cmd_data   <= bus.jdo[34:3];
                if (bus.take_action_ocimem_b)
                    r_cmd_type <= c_CMD_WRITE;
                else if (bus.take_action_ocimem_a)
                    r_cmd_type <= c_CMD_LOAD;
                else
                    r_cmd_type <= c_CMD_READ;
            end else if (w_consume) begin
                r_cmd_valid <= 1'b0;
            end
            if (w_multi_pulse || (w_any_pulse && !w_capture))
                r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = c_ST_IDLE;
        if (r_state == c_ST_IDLE) begin
            if (r_cmd_valid)
                w_next_state = w_cmd_simple ? c_ST_IDLE : c_ST_J_RD;
            else if (bus.read && !r_cpu_rd_ack)
                w_next_state = c_ST_C_RD;
        end
    end

    always_comb begin
        w_ram_rd      = 1'b0;
        w_jtag_we     = 1'b0;
        w_cpu_we      = 1'b0;
        w_ram_addr    = bus.address;
        w_waitrequest = bus.read | bus.write;
        if (!reset && (r_state == c_ST_IDLE)) begin
            if (r_cmd_valid) begin
                case (r_cmd_type)
                    c_CMD_LOAD: begin
                        w_ram_addr = r_cmd_addr;
                        w_ram_rd   = r_cmd_rdflag;
                    end
                    c_CMD_READ: begin
                        w_ram_addr = r_mon_areg;
                        w_ram_rd   = 1'b1;
                    end
                    default: begin
                        w_ram_addr = r_mon_areg;
                        w_jtag_we  = 1'b1;
                    end
                endcase
            end else if (bus.read) begin
                w_ram_rd = !r_cpu_rd_ack;
            end else if (bus.write) begin
                w_cpu_we      = w_cpu_wr_allow;
                w_waitrequest = 1'b0;
            end
        end
        // completion needs no RAM access, so it is not held off by JTAG
        if (bus.read && r_cpu_rd_ack)
            w_waitrequest = 1'b0;
        if (reset)
            w_waitrequest = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mon_areg   <= '0;
            r_mon_dreg   <= '0;
            r_readdata   <= '0;
            r_rd_done    <= 1'b0;
            r_cpu_rd_ack <= 1'b0;
        end else begin
            r_rd_done    <= (r_state == c_ST_J_RD);
            r_cpu_rd_ack <= (r_state == c_ST_C_RD);
            case (r_state)
                c_ST_IDLE: begin
                    if (r_cmd_valid && (r_cmd_type == c_CMD_LOAD))
                        r_mon_areg <= r_cmd_addr;
                    else if (r_cmd_valid && (r_cmd_type == c_CMD_WRITE))
                        r_mon_areg <= r_mon_areg + ADDR_W'(1);
                end
                c_ST_J_RD: begin
                    r_mon_dreg <= r_ram_q;
                    r_mon_areg <= r_mon_areg + ADDR_W'(1);
                end
                c_ST_C_RD: r_readdata <= r_ram_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_jtag_we) begin
            r_mem[w_ram_addr] <= r_cmd_data;
        end else if (w_cpu_we) begin
            for (int i = 0; i < 4; i++)
                if (bus.byteenable[i])
                    r_mem[w_ram_addr][8*i +: 8] <= bus.writedata[8*i +: 8];
        end
        if (w_ram_rd)
            r_ram_q <= r_mem[w_ram_addr];
    end

    assign bus.readdata     = r_readdata;
    assign bus.waitrequest  = w_waitrequest;
    assign bus.MonDReg      = r_mon_dreg;
    assign bus.MonAReg      = r_mon_areg;
    assign bus.jtag_rd_done = r_rd_done;
    assign bus.cmd_overrun  = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_nios2_oci_debug_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_oci_debug_ram_ctrl
// Brief    : Directed self-checking bench with a transaction-level model of
//            the debug RAM, JTAG pointer/data registers and overrun flag.
// Revision : 1.0
// ============================================================================
module tb_nios2_oci_debug_ram_ctrl;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    nios2_oci_debug_ram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    nios2_oci_debug_ram_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    logic [31:0]       m_mem [256];
    logic [ADDR_W-1:0] m_areg = '0;
    logic [31:0]       m_dreg = '0;
    logic              m_done = 1'b0;
    logic              m_ovr  = 1'b0;
    logic              chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.jtag_rd_done === 1'b1)
            done_pulses++;
        if (chk_en) begin
            chk("MonAReg", 32'(bus.MonAReg), 32'(m_areg));
            chk("MonDReg", bus.MonDReg, m_dreg);
            chk("jtag_rd_done", 32'(bus.jtag_rd_done), 32'(m_done));
            chk("cmd_overrun", 32'(bus.cmd_overrun), 32'(m_ovr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse at N: command pending at N+1, pointer/data visible N+2 / N+3
    task automatic jtag_write(input logic [31:0] d);
        bus.jdo = {3'b000, d, 3'b000};
        bus.take_action_ocimem_b = 1'b1;
        tick();
        bus.take_action_ocimem_b = 1'b0;
        tick();
        m_mem[m_areg] = d;
        m_areg = m_areg + 1'b1;
    endtask

    task automatic jtag_load(input logic [ADDR_W-1:0] a, input logic rd);
        bus.jdo = '0;
        bus.jdo[35] = rd;
        bus.jdo[26 +: ADDR_W] = a;
        bus.take_action_ocimem_a = 1'b1;
        tick();
        bus.take_action_ocimem_a = 1'b0;
        tick();
        m_areg = a;
        if (rd) begin
            tick();
            m_dreg = m_mem[m_areg];
            m_done = 1'b1;
            m_areg = m_areg + 1'b1;
            tick();
            m_done = 1'b0;
        end
    endtask

    task automatic jtag_read();
        bus.take_no_action_ocimem_a = 1'b1;
        tick();
        bus.take_no_action_ocimem_a = 1'b0;
        tick();
        tick();
        m_dreg = m_mem[m_areg];
        m_done = 1'b1;
        m_areg = m_areg + 1'b1;
        tick();
        m_done = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
        logic allow;
        bus.address = a;
        bus.writedata = d;
        bus.byteenable = be;
        bus.debugaccess = dbg;
        bus.write = 1'b1;
        @(negedge clk);
        chk("cpu_wr_waitrequest", 32'(bus.waitrequest), 32'd0);
        tick();
        bus.write = 1'b0;
`ifdef NIOS2_OCIMEM_WRITE_PROTECT_EN
        allow = dbg;
`else
        allow = 1'b1;
`endif
        if (allow)
            for (int i = 0; i < 4; i++)
                if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic cpu_read(input logic [7:0] a, output int waits);
        bit got = 0;
        bus.address = a;
        bus.read = 1'b1;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.waitrequest) begin
                waits++;
            end else begin
                got = 1;
                chk("cpu_readdata", bus.readdata, m_mem[a]);
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL cpu_read_timeout: waitrequest still %0d after %0d cycles, required 0", bus.waitrequest, waits);
        end
        tick();
        bus.read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.jdo = '0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.address = '0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.writedata = '0;
        bus.byteenable = '0;
        bus.debugaccess = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        chk("waitrequest_in_reset", 32'(bus.waitrequest), 32'd1);
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_MonAReg", 32'(bus.MonAReg), 32'h0);
        chk("reset_MonDReg", bus.MonDReg, 32'h0);
        chk("reset_readdata", bus.readdata, 32'h0);
        chk("reset_overrun", 32'(bus.cmd_overrun), 32'h0);
        tick();

        // LOAD with read flag
        cpu_write(8'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        jtag_load(8'h10, 1'b1);
        chk("load_rd_MonDReg", bus.MonDReg, 32'hDEADBEEF);
        chk("load_rd_MonAReg", 32'(bus.MonAReg), 32'h11);
        chk("load_rd_pulses", 32'(done_pulses), 32'd1);

        // JTAG writes wrapping through the top of the RAM
        jtag_load(8'hFF, 1'b0);
        jtag_write(32'h1);
        jtag_write(32'h2);
        jtag_write(32'h3);
        chk("wrap_MonAReg", 32'(bus.MonAReg), 32'h02);
        cpu_read(8'hFF, w);
        chk("ram_ff", bus.readdata, 32'h1);
        chk("cpu_rd_waits", 32'(w), 32'd2);
        cpu_read(8'h00, w);
        chk("ram_00", bus.readdata, 32'h2);
        cpu_read(8'h01, w);
        chk("ram_01", bus.readdata, 32'h3);

        // CPU read meets a pending JTAG read in the same IDLE cycle
        cpu_write(8'h20, 32'h12345678, 4'hF, 1'b1);
        cpu_write(8'h02, 32'hCAFEF00D, 4'hF, 1'b1);
        fork
            jtag_read();
            begin
                tick();
                cpu_read(8'h20, w);
            end
        join
        chk("contend_waits", 32'(w), 32'd4);
        chk("contend_readdata", bus.readdata, 32'h12345678);
        chk("contend_MonDReg", bus.MonDReg, 32'hCAFEF00D);

        // simultaneous write and read pulses: write wins, read dropped
        bus.jdo = {3'b000, 32'h55, 3'b000};
        bus.take_action_ocimem_b = 1'b1;
        bus.take_no_action_ocimem_a = 1'b1;
        tick();
        bus.take_action_ocimem_b = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        m_ovr = 1'b1;
        tick();
        m_mem[m_areg] = 32'h55;
        m_areg = m_areg + 1'b1;
        repeat (4) tick();
        chk("overrun_flag", 32'(bus.cmd_overrun), 32'd1);
        chk("overrun_pulses", 32'(done_pulses), 32'd2);
        cpu_read(8'h03, w);
        chk("overrun_ram", bus.readdata, 32'h55);

        // byte-lane write with debugaccess low
        cpu_write(8'h30, 32'h0, 4'hF, 1'b1);
        cpu_write(8'h30, 32'hAABBCCDD, 4'b0101, 1'b0);
        cpu_read(8'h30, w);
`ifdef NIOS2_OCIMEM_WRITE_PROTECT_EN
        chk("be_protected", bus.readdata, 32'h0);
`else
        chk("be_merge", bus.readdata, 32'h00BB00DD);
`endif
        cpu_write(8'h30, 32'h11223344, 4'b1010, 1'b1);
        cpu_read(8'h30, w);

        // reset while the FSM is in J_RD, with another command arriving
        cpu_write(8'h40, 32'h0BADF00D, 4'hF, 1'b1);
        bus.jdo = '0;
        bus.jdo[35] = 1'b1;
        bus.jdo[26 +: ADDR_W] = 8'h40;
        bus.take_action_ocimem_a = 1'b1;
        tick();
        bus.take_action_ocimem_a = 1'b0;
        tick();
        m_areg = 8'h40;
        reset = 1'b1;
        bus.take_no_action_ocimem_a = 1'b1;
        tick();
        reset = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        m_areg = '0;
        m_dreg = '0;
        m_ovr = 1'b0;
        m_done = 1'b0;
        repeat (6) tick();
        chk("rst_jrd_MonDReg", bus.MonDReg, 32'h0);
        chk("rst_jrd_MonAReg", 32'(bus.MonAReg), 32'h0);
        chk("rst_jrd_pulses", 32'(done_pulses), 32'd2);
        chk("rst_jrd_readdata", bus.readdata, 32'h0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
